// File: rtl/cordic_controller_if.sv
// Host-side bus of the CORDIC controller.
// Carries the operation request (start/ready handshake with operands, system,
// mode, iteration count and abort) and the result handshake (valid/ready with
// the final x, y, z).
//   master : the host; drives requests and result-ready, observes the rest
//   slave  : the controller; drives o_ready, o_res_valid and o_res_x/y/z
interface cordic_controller_if #(
  parameter int p_WIDTH  = 32,
  parameter int p_ITER_W = 5
);
  logic                o_ready;
  logic                i_start;
  logic                i_system;
  logic                i_mode;
  logic [p_ITER_W-1:0] i_iters;
  logic [p_WIDTH-1:0]  i_x;
  logic [p_WIDTH-1:0]  i_y;
  logic [p_WIDTH-1:0]  i_z;
  logic                i_abort;
  logic                o_res_valid;
  logic                i_res_ready;
  logic [p_WIDTH-1:0]  o_res_x;
  logic [p_WIDTH-1:0]  o_res_y;
  logic [p_WIDTH-1:0]  o_res_z;

  modport master (
    input  o_ready, o_res_valid, o_res_x, o_res_y, o_res_z,
    output i_start, i_system, i_mode, i_iters, i_x, i_y, i_z,
           i_abort, i_res_ready
  );

  modport slave (
    output o_ready, o_res_valid, o_res_x, o_res_y, o_res_z,
    input  i_start, i_system, i_mode, i_iters, i_x, i_y, i_z,
           i_abort, i_res_ready
  );
endinterface

// File: rtl/cordic_controller.sv
// CORDIC sequencing controller.
// Accepts one operation from the host, loads the CORDIC core with the latched
// operands, issues the iteration-index schedule (hyperbolic mode repeats
// indices 4 and 13) and hands the core's final x/y/z back to the host.
// No arithmetic is performed on x/y/z here.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   host                  host request/result bus (cordic_controller_if.slave)
//   o_core_load           core loads operands, system and mode this cycle
//   o_core_en             core performs one iteration this cycle
//   o_core_iter           iteration index of the current step (0 when idle)
//   o_core_system/mode    latched system / mode
//   o_core_x/y/z          latched initial state
//   i_core_x/y/z          current core state
module cordic_controller #(
  parameter int p_WIDTH    = 32,
  parameter int p_ITER_W   = 5,
  parameter int p_ITER_MAX = 31
) (
  input  logic                i_clk,
  input  logic                i_rst,
  cordic_controller_if.slave  host,
  output logic                o_core_load,
  output logic                o_core_en,
  output logic [p_ITER_W-1:0] o_core_iter,
  output logic                o_core_system,
  output logic                o_core_mode,
  output logic [p_WIDTH-1:0]  o_core_x,
  output logic [p_WIDTH-1:0]  o_core_y,
  output logic [p_WIDTH-1:0]  o_core_z,
  input  logic [p_WIDTH-1:0]  i_core_x,
  input  logic [p_WIDTH-1:0]  i_core_y,
  input  logic [p_WIDTH-1:0]  i_core_z
);

  // One extra bit so N_eff plus both hyperbolic repeats fits.
  localparam int SW = p_ITER_W + 1;
  localparam logic [p_ITER_W-1:0] ITER_MAX = p_ITER_W'(p_ITER_MAX);
  localparam logic [p_ITER_W-1:0] REP_A    = p_ITER_W'(4);
  localparam logic [p_ITER_W-1:0] REP_B    = p_ITER_W'(13);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  state_t              state_q, state_d;
  logic                sys_q, mode_q;
  logic [p_WIDTH-1:0]  x_q, y_q, z_q;
  logic [p_ITER_W-1:0] n_eff_q;
  logic [p_ITER_W-1:0] iter_q;
  logic                rep_q;
  logic [SW-1:0]       steps_left_q;
  logic [SW-1:0]       steps_calc;
  logic                hyp_rep_a, hyp_rep_b, rep_point;

  // Total step count for the latched request: hyperbolic runs repeat index 4
  // and index 13 once each when the schedule reaches them.
  always_comb begin
    hyp_rep_a  = !sys_q && (n_eff_q >= REP_A);
    hyp_rep_b  = !sys_q && (n_eff_q >= REP_B);
    steps_calc = SW'(n_eff_q) + SW'(hyp_rep_a) + SW'(hyp_rep_b);
    rep_point  = !sys_q && !rep_q && (iter_q == REP_A || iter_q == REP_B);
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. Abort returns to IDLE from any busy state and takes
  // priority over the result handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (host.i_start) state_d = LOAD;
      LOAD: begin
        if (host.i_abort)            state_d = IDLE;
        else if (steps_calc != '0)   state_d = ITER;
        else                         state_d = DONE;
      end
      ITER: begin
        if (host.i_abort)                  state_d = IDLE;
        else if (steps_left_q == SW'(1))   state_d = DONE;
      end
      DONE: begin
        if (host.i_abort || host.i_res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state. The result bus is gated so it
  // reads zero outside DONE, and the index reads zero whenever the core is
  // not enabled.
  always_comb begin
    host.o_ready     = 1'b0;
    host.o_res_valid = 1'b0;
    host.o_res_x     = '0;
    host.o_res_y     = '0;
    host.o_res_z     = '0;
    o_core_load      = 1'b0;
    o_core_en        = 1'b0;
    o_core_iter      = '0;
    case (state_q)
      IDLE: host.o_ready = 1'b1;
      LOAD: o_core_load  = 1'b1;
      ITER: begin
        o_core_en   = 1'b1;
        o_core_iter = iter_q;
      end
      DONE: begin
        host.o_res_valid = 1'b1;
        host.o_res_x     = i_core_x;
        host.o_res_y     = i_core_y;
        host.o_res_z     = i_core_z;
      end
      default: ;
    endcase
  end

  // Operand latches and the schedule counters. Operands are captured on the
  // accept edge and held until the next accepted operation. In ITER the
  // index is held for one extra step at each hyperbolic repeat point; the
  // last step leaves the index alone so it never wraps.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sys_q        <= 1'b0;
      mode_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      z_q          <= '0;
      n_eff_q      <= '0;
      iter_q       <= '0;
      rep_q        <= 1'b0;
      steps_left_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (host.i_start) begin
            sys_q   <= host.i_system;
            mode_q  <= host.i_mode;
            x_q     <= host.i_x;
            y_q     <= host.i_y;
            z_q     <= host.i_z;
            n_eff_q <= (host.i_iters > ITER_MAX) ? ITER_MAX : host.i_iters;
          end
        end
        LOAD: begin
          iter_q       <= sys_q ? '0 : p_ITER_W'(1);
          rep_q        <= 1'b0;
          steps_left_q <= steps_calc;
        end
        ITER: begin
          steps_left_q <= steps_left_q - SW'(1);
          if (steps_left_q != SW'(1)) begin
            if (rep_point) begin
              rep_q <= 1'b1;
            end else begin
              rep_q  <= 1'b0;
              iter_q <= iter_q + p_ITER_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_core_system = sys_q;
  assign o_core_mode   = mode_q;
  assign o_core_x      = x_q;
  assign o_core_y      = y_q;
  assign o_core_z      = z_q;

endmodule

// File: tb/tb_cordic_controller.sv
// Testbench for cordic_controller.
// A stand-in core applies a simple, order-sensitive update on every enabled
// step so the returned result reflects both the load and the exact index
// schedule. Expected schedules and results come from a reference model that
// builds the index list directly from the operation rules.
module tb_cordic_controller;
  localparam int W  = 32;
  localparam int IW = 5;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  cordic_controller_if #(.p_WIDTH(W), .p_ITER_W(IW)) host_if ();

  logic          core_load, core_en, core_system, core_mode;
  logic [IW-1:0] core_iter;
  logic [W-1:0]  core_ox, core_oy, core_oz;
  logic [W-1:0]  core_x, core_y, core_z;

  cordic_controller #(.p_WIDTH(W), .p_ITER_W(IW), .p_ITER_MAX(31)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .host          (host_if),
    .o_core_load   (core_load),
    .o_core_en     (core_en),
    .o_core_iter   (core_iter),
    .o_core_system (core_system),
    .o_core_mode   (core_mode),
    .o_core_x      (core_ox),
    .o_core_y      (core_oy),
    .o_core_z      (core_oz),
    .i_core_x      (core_x),
    .i_core_y      (core_y),
    .i_core_z      (core_z)
  );

  // Stand-in core: load copies the operands, each enabled step folds the
  // index into the state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      core_x <= '0;
      core_y <= '0;
      core_z <= '0;
    end else if (core_load) begin
      core_x <= core_ox;
      core_y <= core_oy;
      core_z <= core_oz;
    end else if (core_en) begin
      core_x <= core_x + 32'(core_iter) + 32'd1;
      core_y <= core_y * 32'd3 + 32'(core_iter);
      core_z <= core_z + 32'd1;
    end
  end

  int           checks = 0;
  int           errors = 0;
  int           refSched[$];
  logic [W-1:0] refX, refY, refZ;

  typedef struct {
    bit          sys;
    bit          mode;
    int          iters;
    logic [31:0] x, y, z;
    int          expSteps;
    int          backpressure;
  } vec_t;
  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Reference model: index list straight from the schedule rules, then the
  // stand-in core's update applied over that list.
  task automatic buildReference(input bit sys, input int n,
                                input logic [31:0] x, y, z);
    refSched.delete();
    if (sys) begin
      for (int i = 0; i < n; i++) refSched.push_back(i);
    end else begin
      for (int i = 1; i <= n; i++) begin
        refSched.push_back(i);
        if (i == 4 || i == 13) refSched.push_back(i);
      end
    end
    refX = x; refY = y; refZ = z;
    foreach (refSched[k]) begin
      refX = refX + 32'(refSched[k]) + 32'd1;
      refY = refY * 32'd3 + 32'(refSched[k]);
      refZ = refZ + 32'd1;
    end
  endtask

  // Wait (bounded) for o_ready, present one start for one edge; returns at
  // the negedge of the LOAD cycle with i_start low.
  task automatic startOp(input bit sys, input bit mode, input int iters,
                         input logic [31:0] x, y, z, output bit ok);
    int waited = 0;
    ok = 1'b0;
    @(negedge i_clk);
    while (host_if.o_ready !== 1'b1 && waited < 50) begin
      @(negedge i_clk);
      waited++;
    end
    if (host_if.o_ready !== 1'b1) begin
      checkOutput("ready_wait", 64'(host_if.o_ready), 64'd1);
      return;
    end
    host_if.i_system = sys;
    host_if.i_mode   = mode;
    host_if.i_iters  = IW'(iters);
    host_if.i_x      = x;
    host_if.i_y      = y;
    host_if.i_z      = z;
    host_if.i_start  = 1'b1;
    @(negedge i_clk);
    host_if.i_start  = 1'b0;
    ok = 1'b1;
  endtask

  // Full operation: cycle-by-cycle check of load, schedule, result and
  // release, with optional backpressure and an ignored second start.
  task automatic applyStimulus(input bit sys, input bit mode, input int iters,
                               input logic [31:0] x, y, z, input int expSteps,
                               input int bp, input bit pokeStart);
    int steps;
    bit ok;
    buildReference(sys, iters, x, y, z);
    steps = (expSteps >= 0) ? expSteps : refSched.size();
    startOp(sys, mode, iters, x, y, z, ok);
    if (!ok) return;
    checkOutput("load",        64'(core_load),       64'd1);
    checkOutput("load_no_en",  64'(core_en),         64'd0);
    checkOutput("busy_ready",  64'(host_if.o_ready), 64'd0);
    checkOutput("core_x",      64'(core_ox),         64'(x));
    checkOutput("core_y",      64'(core_oy),         64'(y));
    checkOutput("core_z",      64'(core_oz),         64'(z));
    checkOutput("core_system", 64'(core_system),     64'(sys));
    checkOutput("core_mode",   64'(core_mode),       64'(mode));
    for (int k = 0; k < steps; k++) begin
      @(negedge i_clk);
      checkOutput("step_en",    64'(core_en),   64'd1);
      checkOutput("step_load",  64'(core_load), 64'd0);
      checkOutput("step_valid", 64'(host_if.o_res_valid), 64'd0);
      checkOutput("step_iter",  64'(core_iter),
                  (k < refSched.size()) ? 64'(refSched[k]) : 64'hFFFF);
    end
    @(negedge i_clk);
    checkOutput("done_en",    64'(core_en),             64'd0);
    checkOutput("done_iter",  64'(core_iter),           64'd0);
    checkOutput("done_valid", 64'(host_if.o_res_valid), 64'd1);
    checkOutput("res_x",      64'(host_if.o_res_x),     64'(refX));
    checkOutput("res_y",      64'(host_if.o_res_y),     64'(refY));
    checkOutput("res_z",      64'(host_if.o_res_z),     64'(refZ));
    checkOutput("hold_core_x", 64'(core_ox),            64'(x));
    if (pokeStart) begin
      host_if.i_start = 1'b1;
      host_if.i_x     = ~x;
      host_if.i_iters = IW'(iters + 1);
    end
    for (int b = 0; b < bp; b++) begin
      @(negedge i_clk);
      checkOutput("bp_valid", 64'(host_if.o_res_valid), 64'd1);
      checkOutput("bp_res_x", 64'(host_if.o_res_x),     64'(refX));
      checkOutput("bp_res_z", 64'(host_if.o_res_z),     64'(refZ));
      checkOutput("bp_ready", 64'(host_if.o_ready),     64'd0);
      checkOutput("bp_load",  64'(core_load),           64'd0);
      checkOutput("bp_core_x", 64'(core_ox),            64'(x));
    end
    host_if.i_start     = 1'b0;
    host_if.i_res_ready = 1'b1;
    @(negedge i_clk);
    host_if.i_res_ready = 1'b0;
    checkOutput("release_ready", 64'(host_if.o_ready),     64'd1);
    checkOutput("release_valid", 64'(host_if.o_res_valid), 64'd0);
  endtask

  initial begin
    bit ok;
    bit sawValid;

    i_rst               = 1'b1;
    host_if.i_start     = 1'b0;
    host_if.i_system    = 1'b0;
    host_if.i_mode      = 1'b0;
    host_if.i_iters     = '0;
    host_if.i_x         = '0;
    host_if.i_y         = '0;
    host_if.i_z         = '0;
    host_if.i_abort     = 1'b0;
    host_if.i_res_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    checkOutput("rst_ready", 64'(host_if.o_ready),     64'd1);
    checkOutput("rst_valid", 64'(host_if.o_res_valid), 64'd0);
    checkOutput("rst_load",  64'(core_load),           64'd0);
    checkOutput("rst_en",    64'(core_en),             64'd0);
    checkOutput("rst_iter",  64'(core_iter),           64'd0);
    checkOutput("rst_core_x", 64'(core_ox),            64'd0);
    i_rst = 1'b0;

    // Directed table: {system, mode, N, x, y, z, expected steps, backpressure}.
    vecs.push_back('{1'b1, 1'b1, 4,  32'h26DD3B6A, 32'h0, 32'h3243F6A9, 4,  0});
    vecs.push_back('{1'b0, 1'b1, 5,  32'h10000000, 32'h0, 32'h08000000, 6,  1});
    vecs.push_back('{1'b0, 1'b0, 14, 32'h20000000, 32'h10000000, 32'h0, 16, 0});
    vecs.push_back('{1'b1, 1'b0, 31, 32'h12345678, 32'h9ABCDEF0, 32'h0, 31, 2});
    vecs.push_back('{1'b0, 1'b1, 0,  32'hCAFEF00D, 32'hDEADBEEF, 32'h55, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 0,  32'h11111111, 32'h22222222, 32'h33333333, 0, 1});
    vecs.push_back('{1'b0, 1'b1, 4,  32'h1, 32'h2, 32'h3, 5, 0});
    vecs.push_back('{1'b0, 1'b0, 13, 32'h4, 32'h5, 32'h6, 15, 0});
    vecs.push_back('{1'b0, 1'b1, 31, 32'h7, 32'h8, 32'h9, 33, 0});
    vecs.push_back('{1'b0, 1'b1, 3,  32'hA, 32'hB, 32'hC, 3, 0});
    vecs.push_back('{1'b1, 1'b0, 1,  32'hD, 32'hE, 32'hF, 1, 0});
    foreach (vecs[i])
      applyStimulus(vecs[i].sys, vecs[i].mode, vecs[i].iters, vecs[i].x,
                    vecs[i].y, vecs[i].z, vecs[i].expSteps,
                    vecs[i].backpressure, 1'b0);

    // Backpressure for 10 cycles with a second start held during it.
    applyStimulus(1'b1, 1'b1, 4, 32'h0BADF00D, 32'h1, 32'h2, 4, 10, 1'b1);

    // Abort on the third ITER step of a circular N=10 operation.
    startOp(1'b1, 1'b1, 10, 32'h100, 32'h200, 32'h300, ok);
    repeat (3) @(negedge i_clk);
    checkOutput("abort_pre_iter", 64'(core_iter), 64'd2);
    host_if.i_abort = 1'b1;
    @(negedge i_clk);
    host_if.i_abort = 1'b0;
    checkOutput("abort_ready", 64'(host_if.o_ready), 64'd1);
    checkOutput("abort_en",    64'(core_en),         64'd0);
    checkOutput("abort_iter",  64'(core_iter),       64'd0);
    sawValid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (host_if.o_res_valid) sawValid = 1'b1;
      @(negedge i_clk);
    end
    checkOutput("abort_no_result", 64'(sawValid), 64'd0);

    // Abort during LOAD.
    startOp(1'b0, 1'b1, 6, 32'h1, 32'h2, 32'h3, ok);
    host_if.i_abort = 1'b1;
    @(negedge i_clk);
    host_if.i_abort = 1'b0;
    checkOutput("abort_load_ready", 64'(host_if.o_ready), 64'd1);
    checkOutput("abort_load_en",    64'(core_en),         64'd0);

    // Abort in DONE together with res_ready.
    startOp(1'b1, 1'b0, 0, 32'h44, 32'h55, 32'h66, ok);
    @(negedge i_clk);
    checkOutput("n0_valid", 64'(host_if.o_res_valid), 64'd1);
    host_if.i_abort     = 1'b1;
    host_if.i_res_ready = 1'b1;
    @(negedge i_clk);
    host_if.i_abort     = 1'b0;
    host_if.i_res_ready = 1'b0;
    checkOutput("abort_done_ready", 64'(host_if.o_ready),     64'd1);
    checkOutput("abort_done_valid", 64'(host_if.o_res_valid), 64'd0);

    // Abort in IDLE alongside start: start still accepted.
    @(negedge i_clk);
    host_if.i_system = 1'b1;
    host_if.i_iters  = '0;
    host_if.i_x      = 32'h77;
    host_if.i_y      = 32'h88;
    host_if.i_z      = 32'h99;
    host_if.i_start  = 1'b1;
    host_if.i_abort  = 1'b1;
    @(negedge i_clk);
    host_if.i_start  = 1'b0;
    host_if.i_abort  = 1'b0;
    checkOutput("idle_abort_load", 64'(core_load), 64'd1);
    @(negedge i_clk);
    checkOutput("idle_abort_res_x", 64'(host_if.o_res_x), 64'h77);
    host_if.i_res_ready = 1'b1;
    @(negedge i_clk);
    host_if.i_res_ready = 1'b0;

    // Reset asserted mid-ITER clears everything without waiting for a clock.
    startOp(1'b1, 1'b1, 8, 32'hAAAA, 32'hBBBB, 32'hCCCC, ok);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    checkOutput("midrst_ready",  64'(host_if.o_ready),     64'd1);
    checkOutput("midrst_en",     64'(core_en),             64'd0);
    checkOutput("midrst_iter",   64'(core_iter),           64'd0);
    checkOutput("midrst_core_x", 64'(core_ox),             64'd0);
    checkOutput("midrst_sys",    64'(core_system),         64'd0);
    checkOutput("midrst_valid",  64'(host_if.o_res_valid), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Randomized operations against the reference model.
    for (int r = 0; r < 25; r++)
      applyStimulus(1'($urandom), 1'($urandom), int'($urandom_range(0, 31)),
                    $urandom, $urandom, $urandom, -1,
                    int'($urandom_range(0, 3)), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cordic_controller.md
Name: cordic_controller

Overview:
Sequences one CORDIC core (p_WIDTH datapath) on behalf of a single host.
- Accepts an operation via a ready/start handshake: x, y, z, system (circular/hyperbolic), mode (rotation/vectoring) and iteration count.
- Loads the core, then issues the correct iteration-index schedule, including the hyperbolic repeat iterations.
- Presents the final x, y, z with a valid/ready handshake.
- Sits between the host register interface and the cordic core; it does no arithmetic on x/y/z.

Parameters:
p_WIDTH, 32, datapath width of x, y, z
p_ITER_W, 5, width of iteration index and count
p_ITER_MAX, 31, maximum base iteration count; larger requests are clamped

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
o_ready  out  1  controller idle, will accept i_start
i_start  in  1  start request; accepted when i_start & o_ready
i_system  in  1  1 = circular, 0 = hyperbolic
i_mode  in  1  1 = rotation, 0 = vectoring
i_iters  in  p_ITER_W  base iteration count N
i_x, i_y, i_z  in  p_WIDTH each  initial state
i_abort  in  1  cancel operation in progress
o_res_valid  out  1  result available
i_res_ready  in  1  host consumes result
o_res_x, o_res_y, o_res_z  out  p_WIDTH each  result
o_core_load  out  1  core loads o_core_x/y/z, mode, system this cycle
o_core_en  out  1  core performs one iteration this cycle
o_core_iter  out  p_ITER_W  iteration index for this step
o_core_system, o_core_mode  out  1 each  latched i_system / i_mode
o_core_x, o_core_y, o_core_z  out  p_WIDTH each  latched initial state
i_core_x, i_core_y, i_core_z  in  p_WIDTH each  current core state

Behaviour:
- States: IDLE, LOAD, ITER, DONE.
- Reset (any time, including mid-operation): state IDLE, o_ready=1, every other output 0, all internal latches cleared.
- IDLE
  - o_ready=1.
  - On i_start, latch all operands; N_eff = min(i_iters, p_ITER_MAX); go to LOAD.
- LOAD (one cycle)
  - o_core_load=1.
  - Step count S computed from N_eff.
  - Circular: S=N_eff, indices 0..N_eff-1.
  - Hyperbolic: indices 1..N_eff; index 4 is issued twice if N_eff>=4, and index 13 twice if N_eff>=13. S = N_eff + (N_eff>=4) + (N_eff>=13).
  - Next state: ITER if S>0, else DONE.
- ITER
  - o_core_en=1 for exactly S consecutive cycles; o_core_iter follows the schedule.
  - A repeat flag holds the index for one extra cycle at each repeat point.
  - After the S-th step, go to DONE.
- DONE
  - o_res_valid=1; o_res_x/y/z = i_core_x/y/z (core is not enabled, so values are stable).
  - Hold until i_res_ready, then go to IDLE. o_ready rises the following cycle; there is no same-cycle restart.
- Timing
  - Accept edge at cycle 0; LOAD in cycle 1; o_core_en in cycles 2..S+1; o_res_valid from cycle S+2.
  - Each operation takes S+2 cycles plus backpressure.
- i_start while o_ready=0: ignored.
- i_abort in LOAD, ITER or DONE: IDLE on the next edge.
  - o_core_en and o_res_valid drop.
  - No result is produced.
  - i_abort in IDLE has no effect.
  - i_abort wins over simultaneous i_res_ready.
- o_core_* operand and mode outputs stay constant from LOAD through DONE; they are cleared only by reset.
- o_core_en and o_core_load are never both 1 in the same cycle.
- o_core_iter is 0 whenever o_core_en=0.
- The index counter never wraps: the maximum index is p_ITER_MAX, which is representable in p_ITER_W bits.

Test Plan:
- Circular rotation, N=4, x=0.607253, y=0, z=45deg, start at cycle 0:
  - o_core_load in cycle 1.
  - o_core_iter = 0,1,2,3 in cycles 2-5.
  - o_res_valid in cycle 6 with o_res_* equal to the core outputs.
- Hyperbolic, N=5: o_core_iter = 1,2,3,4,4,5 (S=6); valid in cycle 8.
- Hyperbolic, N=14: S=16; index 4 and index 13 each appear twice; last index 14. Request N=31 in circular mode: S=31.
- Backpressure: i_res_ready held 0 for 10 cycles.
  - o_res_valid and o_res_* stay stable.
  - A second i_start is ignored.
  - After i_res_ready=1: o_ready=1 one cycle later.
- i_abort during ITER step 3 of N=10: no o_res_valid, IDLE next cycle. i_rst asserted mid-ITER: all outputs 0 immediately.
- N=0: LOAD, then DONE in cycle 2 with results equal to the initial core values; no o_core_en pulse.
